// File: rtl/cpu_trace_buffer_pkg.sv
// Shared types and helpers for the CPU trace buffer: FSM state encoding and drop-counter saturation.
package cpu_trace_buffer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_ARMED     = 2'd1,
        ST_TRIGGERED = 2'd2,
        ST_DONE      = 2'd3
    } state_e;

    localparam int unsigned DROP_W   = 8;
    localparam int unsigned INC_W    = DROP_W + 1;
    localparam int unsigned DROP_MAX = (1 << DROP_W) - 1;

    // Add a per-cycle drop increment to the counter, clamping at DROP_MAX.
    function automatic logic [DROP_W-1:0] sat_add(input logic [DROP_W-1:0] a,
                                                  input logic [INC_W-1:0]  b);
        logic [INC_W:0] s;
        s = (INC_W+1)'(a) + (INC_W+1)'(b);
        return (s > (INC_W+1)'(DROP_MAX)) ? DROP_W'(DROP_MAX) : s[DROP_W-1:0];
    endfunction

endpackage

// File: rtl/cpu_trace_buffer_fifo.sv
// Trace FIFO: DEPTH x W register RAM; a write into a full FIFO without a pop overwrites the oldest entry.
module cpu_trace_buffer_fifo #(
    parameter int unsigned W     = 8,
    parameter int unsigned DEPTH = 16,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             flush_i,
    input  logic             wr_en_i,
    input  logic [W-1:0]     wr_data_i,
    input  logic             rd_en_i,
    output logic             rd_valid_o,
    output logic [W-1:0]     rd_data_o,
    output logic [CNT_W-1:0] level_o,
    output logic             full_o
);

    logic [W-1:0]     mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [CNT_W-1:0] level_q;
    logic             pop;
    logic             ovw;

    assign full_o     = (level_q == CNT_W'(DEPTH));
    assign rd_valid_o = (level_q != '0);
    assign pop        = rd_en_i && rd_valid_o;
    assign ovw        = wr_en_i && full_o && !pop;
    assign level_o    = level_q;
    // Head is forced to zero when empty so stale RAM never reaches the outputs.
    assign rd_data_o  = rd_valid_o ? mem_q[rd_ptr_q] : '0;

    always_ff @(posedge CLK) begin
        if (wr_en_i && !flush_i) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
        end else begin
            if (wr_en_i) begin
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            end
            if (pop || ovw) begin
                rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            end
            if (wr_en_i && !pop && !full_o) begin
                level_q <= level_q + CNT_W'(1);
            end else if (pop && !wr_en_i) begin
                level_q <= level_q - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/cpu_trace_buffer.sv
// CPU write-event trace buffer: per-channel pending slots, round-robin arbiter, arm/trigger/post-count FSM.
// Define CPU_TRACE_TIMESTAMP_EN to store a free-running cycle timestamp with every entry.
module cpu_trace_buffer
    import cpu_trace_buffer_pkg::*;
#(
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NCH    = 2,
    parameter int unsigned DEPTH  = 16,
    parameter int unsigned TS_W   = 16,
    localparam int unsigned CH_W  = (NCH > 1) ? $clog2(NCH) : 1,
    localparam int unsigned CNT_W = $clog2(DEPTH) + 1
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  arm,
    input  logic [ADDR_W-1:0]     trig_addr,
    input  logic [CNT_W-1:0]      post_cnt,
    input  logic [NCH-1:0]        ev_valid,
    input  logic [NCH*ADDR_W-1:0] ev_addr,
    input  logic [NCH*DATA_W-1:0] ev_data,
    output logic                  rd_valid,
    input  logic                  rd_ready,
    output logic [CH_W-1:0]       rd_chan,
    output logic [ADDR_W-1:0]     rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic [TS_W-1:0]       rd_ts,
    output logic [1:0]            state,
    output logic [CNT_W-1:0]      level,
    output logic [7:0]            drop_cnt
);

`ifdef CPU_TRACE_TIMESTAMP_EN
    localparam int unsigned ENT_W = TS_W + CH_W + ADDR_W + DATA_W;
`else
    localparam int unsigned ENT_W = CH_W + ADDR_W + DATA_W;
`endif

    logic [NCH-1:0]    pend_v_q;
    logic [ADDR_W-1:0] pend_addr_q [NCH];
    logic [DATA_W-1:0] pend_data_q [NCH];
    logic [CH_W-1:0]   rr_q;
    logic [CH_W-1:0]   rr_d;
    state_e            state_q;
    logic [CNT_W-1:0]  remain_q;
    logic [DROP_W-1:0] drop_q;

    logic              cap_en;
    logic              gnt_v;
    logic [CH_W-1:0]   gnt_idx;
    logic [ADDR_W-1:0] gnt_addr;
    logic [DATA_W-1:0] gnt_data;
    logic              fifo_full;
    logic              blocked;
    logic              push;
    logic [NCH-1:0]    slot_load;
    logic [NCH-1:0]    slot_clr;
    logic [INC_W-1:0]  drop_inc;
    logic [ENT_W-1:0]  wr_ent;
    logic [ENT_W-1:0]  rd_ent;

    assign cap_en   = (state_q == ST_ARMED) || (state_q == ST_TRIGGERED);
    assign gnt_addr = pend_addr_q[gnt_idx];
    assign gnt_data = pend_data_q[gnt_idx];
    // After the trigger a full FIFO keeps its history; the granted entry is discarded instead.
    assign blocked  = (state_q == ST_TRIGGERED) && fifo_full && !rd_ready;
    assign push     = gnt_v && !blocked && !arm;

    // Round-robin search starting at rr_q over full pending slots.
    always_comb begin : arb
        int unsigned j;
        j       = 0;
        gnt_v   = 1'b0;
        gnt_idx = '0;
        for (int k = 0; k < NCH; k++) begin
            j = (32'(rr_q) + 32'(k)) % NCH;
            if (!gnt_v && cap_en && pend_v_q[j]) begin
                gnt_v   = 1'b1;
                gnt_idx = CH_W'(j);
            end
        end
        rr_d = (32'(gnt_idx) == NCH - 1) ? '0 : gnt_idx + CH_W'(1);
    end

    // A slot accepts a new event when empty or when its current entry leaves this cycle.
    always_comb begin
        slot_load = '0;
        slot_clr  = '0;
        drop_inc  = '0;
        for (int c = 0; c < NCH; c++) begin
            if (cap_en && ev_valid[c]) begin
                if (!pend_v_q[c] || (gnt_v && gnt_idx == CH_W'(c))) begin
                    slot_load[c] = 1'b1;
                end else begin
                    drop_inc = drop_inc + INC_W'(1);
                end
            end else if (gnt_v && gnt_idx == CH_W'(c)) begin
                slot_clr[c] = 1'b1;
            end
        end
        if (gnt_v && blocked) begin
            drop_inc = drop_inc + INC_W'(1);
        end
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            pend_v_q <= '0;
            rr_q     <= '0;
            for (int c = 0; c < NCH; c++) begin
                pend_addr_q[c] <= '0;
                pend_data_q[c] <= '0;
            end
        end else if (arm) begin
            pend_v_q <= '0;
        end else begin
            if (gnt_v) begin
                rr_q <= rr_d;
            end
            for (int c = 0; c < NCH; c++) begin
                if (slot_load[c]) begin
                    pend_v_q[c]    <= 1'b1;
                    pend_addr_q[c] <= ev_addr[c*ADDR_W +: ADDR_W];
                    pend_data_q[c] <= ev_data[c*DATA_W +: DATA_W];
                end else if (slot_clr[c]) begin
                    pend_v_q[c] <= 1'b0;
                end
            end
        end
    end

    // Capture FSM, post-trigger countdown and drop counter; arm overrides everything.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q  <= ST_IDLE;
            remain_q <= '0;
            drop_q   <= '0;
        end else if (arm) begin
            state_q  <= ST_ARMED;
            remain_q <= '0;
            drop_q   <= '0;
        end else begin
            drop_q <= sat_add(drop_q, drop_inc);
            case (state_q)
                ST_ARMED: begin
                    if (push && gnt_addr == trig_addr) begin
                        remain_q <= post_cnt;
                        state_q  <= (post_cnt == '0) ? ST_DONE : ST_TRIGGERED;
                    end
                end
                ST_TRIGGERED: begin
                    if (push) begin
                        remain_q <= remain_q - CNT_W'(1);
                        if (remain_q == CNT_W'(1)) begin
                            state_q <= ST_DONE;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef CPU_TRACE_TIMESTAMP_EN
    logic [TS_W-1:0] ts_q;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            ts_q <= '0;
        end else if (arm) begin
            ts_q <= '0;
        end else begin
            ts_q <= ts_q + TS_W'(1);
        end
    end

    assign wr_ent = {ts_q, gnt_idx, gnt_addr, gnt_data};
    assign rd_ts  = rd_ent[ENT_W-1 -: TS_W];
`else
    assign wr_ent = {gnt_idx, gnt_addr, gnt_data};
    assign rd_ts  = '0;
`endif

    cpu_trace_buffer_fifo #(
        .W     (ENT_W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .CLK        (CLK),
        .RST        (RST),
        .flush_i    (arm),
        .wr_en_i    (push),
        .wr_data_i  (wr_ent),
        .rd_en_i    (rd_ready),
        .rd_valid_o (rd_valid),
        .rd_data_o  (rd_ent),
        .level_o    (level),
        .full_o     (fifo_full)
    );

    assign rd_chan  = rd_ent[ADDR_W+DATA_W +: CH_W];
    assign rd_addr  = rd_ent[DATA_W +: ADDR_W];
    assign rd_data  = rd_ent[DATA_W-1:0];
    assign state    = state_q;
    assign drop_cnt = drop_q;

endmodule

// File: tb/tb_cpu_trace_buffer.sv
// Directed self-checking bench for cpu_trace_buffer (ADDR_W=DATA_W=32, NCH=2, DEPTH=16, TS_W=16).
module tb_cpu_trace_buffer;

    localparam int unsigned AW = 32;
    localparam int unsigned DW = 32;
    localparam int unsigned NC = 2;
    localparam int unsigned DP = 16;
    localparam int unsigned TW = 16;
    localparam int unsigned CW = 1;
    localparam int unsigned KW = 5;

    logic           CLK;
    logic           RST;
    logic           arm;
    logic [AW-1:0]  trig_addr;
    logic [KW-1:0]  post_cnt;
    logic [NC-1:0]  ev_valid;
    logic [NC*AW-1:0] ev_addr;
    logic [NC*DW-1:0] ev_data;
    logic           rd_valid;
    logic           rd_ready;
    logic [CW-1:0]  rd_chan;
    logic [AW-1:0]  rd_addr;
    logic [DW-1:0]  rd_data;
    logic [TW-1:0]  rd_ts;
    logic [1:0]     state;
    logic [KW-1:0]  level;
    logic [7:0]     drop_cnt;

    int n_vec;
    int n_err;

    cpu_trace_buffer #(
        .ADDR_W (AW), .DATA_W (DW), .NCH (NC), .DEPTH (DP), .TS_W (TW)
    ) dut (
        .CLK       (CLK),
        .RST       (RST),
        .arm       (arm),
        .trig_addr (trig_addr),
        .post_cnt  (post_cnt),
        .ev_valid  (ev_valid),
        .ev_addr   (ev_addr),
        .ev_data   (ev_data),
        .rd_valid  (rd_valid),
        .rd_ready  (rd_ready),
        .rd_chan   (rd_chan),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_ts     (rd_ts),
        .state     (state),
        .level     (level),
        .drop_cnt  (drop_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    task automatic do_arm(input logic [AW-1:0] ta, input logic [KW-1:0] pc);
        trig_addr = ta;
        post_cnt  = pc;
        arm       = 1'b1;
        tick();
        arm       = 1'b0;
    endtask

    task automatic ev1(input int ch, input logic [AW-1:0] a, input logic [DW-1:0] d);
        ev_valid              = '0;
        ev_valid[ch]          = 1'b1;
        ev_addr[ch*AW +: AW]  = a;
        ev_data[ch*DW +: DW]  = d;
        tick();
        ev_valid              = '0;
    endtask

    task automatic pop1();
        rd_ready = 1'b1;
        tick();
        rd_ready = 1'b0;
    endtask

    task automatic test_reset();
        RST = 1'b1; arm = 1'b0; rd_ready = 1'b0; ev_valid = '0; ev_addr = '0; ev_data = '0;
        trig_addr = '0; post_cnt = '0;
        idle(2);
        RST = 1'b0;
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL rst_state got %0d want 0", state); end
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL rst_level got %0d want 0", level); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid got %0b want 0", rd_valid); end
        n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rst_drop got %0d want 0", drop_cnt); end
        n_vec++; if (rd_addr !== 32'd0 || rd_data !== 32'd0 || rd_ts !== 16'd0)
            begin n_err++; $display("FAIL rst_head got %h/%h/%h want 0", rd_addr, rd_data, rd_ts); end
        // Events in IDLE are neither stored nor counted as drops.
        ev1(0, 32'd7, 32'd7);
        ev1(1, 32'd8, 32'd8);
        idle(2);
        n_vec++; if (level !== 5'd0 || drop_cnt !== 8'd0)
            begin n_err++; $display("FAIL idle_ignore level=%0d drop=%0d want 0/0", level, drop_cnt); end
    endtask

    task automatic test_single();
        do_arm(32'hFFFF_FFFF, 5'd0);
        n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL arm_state got %0d want 1", state); end
        ev1(1, 32'd5, 32'h1234);
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL lat_n1 rd_valid got %0b want 0", rd_valid); end
        tick();
        n_vec++; if (rd_valid !== 1'b1) begin n_err++; $display("FAIL lat_n2 rd_valid got %0b want 1", rd_valid); end
        n_vec++; if (rd_chan !== 1'b1) begin n_err++; $display("FAIL single_chan got %0d want 1", rd_chan); end
        n_vec++; if (rd_addr !== 32'd5) begin n_err++; $display("FAIL single_addr got %0h want 5", rd_addr); end
        n_vec++; if (rd_data !== 32'h1234) begin n_err++; $display("FAIL single_data got %0h want 1234", rd_data); end
        idle(2);
        n_vec++; if (rd_addr !== 32'd5 || rd_valid !== 1'b1)
            begin n_err++; $display("FAIL head_hold addr=%0h valid=%0b want 5/1", rd_addr, rd_valid); end
        pop1();
        n_vec++; if (level !== 5'd0 || rd_valid !== 1'b0)
            begin n_err++; $display("FAIL single_pop level=%0d valid=%0b want 0/0", level, rd_valid); end
    endtask

    task automatic test_round_robin();
        do_arm(32'hFFFF_FFFF, 5'd0);
        // Both channels fire together every other cycle; grant-and-refill must avoid drops.
        for (int b = 0; b < 3; b++) begin
            ev_valid = 2'b11;
            ev_addr  = {32'(32'h101 + 2*b), 32'(32'h100 + 2*b)};
            ev_data  = {32'(32'hB0 + b), 32'(32'hA0 + b)};
            tick();
            ev_valid = '0;
            tick();
        end
        idle(3);
        n_vec++; if (level !== 5'd6) begin n_err++; $display("FAIL rr_level got %0d want 6", level); end
        n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL rr_drop got %0d want 0", drop_cnt); end
        for (int i = 0; i < 6; i++) begin
            n_vec++; if (rd_chan !== CW'(i % 2))
                begin n_err++; $display("FAIL rr_chan[%0d] got %0d want %0d", i, rd_chan, i % 2); end
            n_vec++; if (rd_addr !== 32'(32'h100 + i))
                begin n_err++; $display("FAIL rr_addr[%0d] got %0h want %0h", i, rd_addr, 32'h100 + i); end
            pop1();
        end
    endtask

    task automatic test_window();
        logic [AW-1:0] exp_a;
        do_arm(32'h40, 5'd3);
        for (int a = 0; a < 20; a++) ev1(0, 32'(a), 32'(a + 1000));
        ev1(0, 32'h40, 32'hDEAD);
        idle(2);
        n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL win_trig_state got %0d want 2", state); end
        n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL win_full got %0d want 16", level); end
        // Pop the three oldest pre-trigger entries to make room for the post-trigger entries.
        for (int i = 0; i < 3; i++) begin
            n_vec++; if (rd_addr !== 32'(5 + i))
                begin n_err++; $display("FAIL win_old[%0d] got %0h want %0h", i, rd_addr, 5 + i); end
            pop1();
        end
        for (int i = 0; i < 5; i++) ev1(0, 32'(32'h41 + i), 32'(i));
        idle(3);
        n_vec++; if (state !== 2'd3) begin n_err++; $display("FAIL win_done got %0d want 3", state); end
        n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL win_level got %0d want 16", level); end
        n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL win_drop got %0d want 0", drop_cnt); end
        for (int i = 0; i < 16; i++) begin
            if (i < 12)       exp_a = 32'(8 + i);
            else if (i == 12) exp_a = 32'h40;
            else              exp_a = 32'(32'h41 + i - 13);
            n_vec++; if (rd_addr !== exp_a)
                begin n_err++; $display("FAIL win_entry[%0d] got %0h want %0h", i, rd_addr, exp_a); end
            pop1();
        end
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL win_drain got %0d want 0", level); end
    endtask

    task automatic test_post_full();
        do_arm(32'h40, 5'd8);
        for (int a = 0; a < 16; a++) ev1(0, 32'(a), 32'(a));
        ev1(0, 32'h40, 32'h40);
        for (int i = 0; i < 8; i++) ev1(0, 32'(32'h41 + i), 32'(i));
        idle(3);
        n_vec++; if (state !== 2'd2) begin n_err++; $display("FAIL pf_state got %0d want 2", state); end
        n_vec++; if (drop_cnt !== 8'd8) begin n_err++; $display("FAIL pf_drop got %0d want 8", drop_cnt); end
        n_vec++; if (level !== 5'd16) begin n_err++; $display("FAIL pf_level got %0d want 16", level); end
        n_vec++; if (rd_addr !== 32'd1) begin n_err++; $display("FAIL pf_head got %0h want 1", rd_addr); end
    endtask

    task automatic test_async_reset();
        #3;
        RST = 1'b1;
        #1;
        n_vec++; if (state !== 2'd0) begin n_err++; $display("FAIL arst_state got %0d want 0", state); end
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL arst_level got %0d want 0", level); end
        n_vec++; if (rd_valid !== 1'b0) begin n_err++; $display("FAIL arst_valid got %0b want 0", rd_valid); end
        n_vec++; if (drop_cnt !== 8'd0) begin n_err++; $display("FAIL arst_drop got %0d want 0", drop_cnt); end
        tick();
        RST = 1'b0;
        idle(2);
        n_vec++; if (state !== 2'd0 || level !== 5'd0)
            begin n_err++; $display("FAIL arst_after state=%0d level=%0d want 0/0", state, level); end
    endtask

    task automatic test_arm_priority();
        do_arm(32'h40, 5'd0);
        ev1(0, 32'h40, 32'h55);
        // The trigger entry is granted in this cycle; arm must win and flush it.
        arm = 1'b1;
        tick();
        arm = 1'b0;
        n_vec++; if (state !== 2'd1) begin n_err++; $display("FAIL armpri_state got %0d want 1", state); end
        idle(2);
        n_vec++; if (level !== 5'd0) begin n_err++; $display("FAIL armpri_level got %0d want 0", level); end
        ev1(0, 32'h40, 32'h66);
        idle(2);
        n_vec++; if (state !== 2'd3) begin n_err++; $display("FAIL post0_state got %0d want 3", state); end
        n_vec++; if (level !== 5'd1 || rd_data !== 32'h66)
            begin n_err++; $display("FAIL post0_entry level=%0d data=%0h want 1/66", level, rd_data); end
    endtask

    task automatic test_timestamp();
        logic [TW-1:0] t1;
        logic [TW-1:0] t2;
        do_arm(32'hFFFF_FFFF, 5'd0);
        idle(2);
        ev1(0, 32'd1, 32'd1);
        idle(3);
        ev1(0, 32'd2, 32'd2);
        idle(2);
        n_vec++; if (level !== 5'd2) begin n_err++; $display("FAIL ts_level got %0d want 2", level); end
        t1 = rd_ts;
        pop1();
        t2 = rd_ts;
        pop1();
`ifdef CPU_TRACE_TIMESTAMP_EN
        n_vec++; if (16'(t2 - t1) !== 16'd4) begin n_err++; $display("FAIL ts_delta got %0d want 4", 16'(t2 - t1)); end
        n_vec++; if (t1 !== 16'd3) begin n_err++; $display("FAIL ts_first got %0d want 3", t1); end
`else
        n_vec++; if (t1 !== 16'd0) begin n_err++; $display("FAIL ts_zero1 got %0d want 0", t1); end
        n_vec++; if (t2 !== 16'd0) begin n_err++; $display("FAIL ts_zero2 got %0d want 0", t2); end
`endif
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_single();
        test_round_robin();
        test_window();
        test_post_full();
        test_async_reset();
        test_arm_priority();
        test_timestamp();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
